// File: rtl/mio_bus_responder_pkg.sv
// Shared constants for the MEM-stage responder: region codes, base addresses,
// state encodings and the address decode helper.
package mio_bus_responder_pkg;

  localparam logic [3:0] MIO_REGION_RAM  = 4'h0;
  localparam logic [3:0] MIO_REGION_GPIO = 4'hE;
  localparam logic [3:0] MIO_REGION_CNT  = 4'hF;

  localparam logic [31:0] MIO_BASE_RAM  = 32'h0000_0000;
  localparam logic [31:0] MIO_BASE_GPIO = 32'hE000_0000;
  localparam logic [31:0] MIO_BASE_CNT  = 32'hF000_0000;
  localparam logic [31:0] MIO_ERR_ADDR  = 32'hF000_0004;

  localparam logic [1:0] MIO_S_IDLE   = 2'd0;
  localparam logic [1:0] MIO_S_ACCESS = 2'd1;
  localparam logic [1:0] MIO_S_WAIT   = 2'd2;
  localparam logic [1:0] MIO_S_DONE   = 2'd3;

  typedef enum logic [1:0] {
    RGN_RAM  = 2'd0,
    RGN_GPIO = 2'd1,
    RGN_CNT  = 2'd2,
    RGN_NONE = 2'd3
  } mio_rgn_e;

  function automatic mio_rgn_e mio_decode(input logic [31:0] addr);
    mio_rgn_e rgn;
    case (addr[31:28])
      MIO_REGION_RAM:  rgn = RGN_RAM;
      MIO_REGION_GPIO: rgn = RGN_GPIO;
      MIO_REGION_CNT:  rgn = RGN_CNT;
      default:         rgn = RGN_NONE;
    endcase
    return rgn;
  endfunction

endpackage

// File: rtl/mio_bus_responder_counter.sv
// mio_counter: free-running 32-bit counter with a load port; a load takes
// priority over the increment in the same cycle, and the count wraps to 0.
module mio_counter
  import mio_bus_responder_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic [31:0] i_load_val,
  output logic [31:0] o_count
);

  logic [31:0] r_count;

  // count register: load wins, otherwise increment with natural wrap
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= 32'd0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else begin
      r_count <= r_count + 32'd1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/mio_bus_responder.sv
// mio_bus_responder: responder for the CPU MEM-stage handshake, decoding RAM,
// GPIO and counter. Define MIO_BUS_ERR_EN to add bus_err and err_addr (0xF0000004).
module mio_bus_responder
  import mio_bus_responder_pkg::*;
#(
  parameter int RAM_LAT = 1,
  parameter int LED_W   = 16,
  parameter int SW_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_req,
  input  logic             mem_we,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_wdata,
  output logic [31:0]      mem_rdata,
  output logic             MIO_ready,
  output logic [29:0]      ram_addr,
  output logic             ram_we,
  output logic [31:0]      ram_wdata,
  input  logic [31:0]      ram_rdata,
  input  logic [SW_W-1:0]  sw_in,
  output logic [LED_W-1:0] led_out
`ifdef MIO_BUS_ERR_EN
  ,
  output logic             bus_err
`endif
);

  localparam logic [2:0] WAIT_INIT    = (RAM_LAT > 0) ? 3'(RAM_LAT - 1) : 3'd0;
  localparam bit         RAM_HAS_WAIT = (RAM_LAT > 0);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  mio_rgn_e         r_rgn;
  mio_rgn_e         w_req_rgn;
  logic             r_we;
  logic [31:0]      r_wdata;
  logic [2:0]       r_wait_cnt;
  logic [31:0]      r_mem_rdata;
  logic             r_mio_ready;
  logic [29:0]      r_ram_addr;
  logic             r_ram_we;
  logic [31:0]      r_ram_wdata;
  logic [LED_W-1:0] r_led;
  logic [31:0]      w_count;
  logic             w_cnt_load;
  logic [31:0]      w_rd_val;
  logic [31:0]      w_sw_ext;
  logic             w_err_sel;
  logic [31:0]      w_err_word;
  logic             w_req_take;
  logic             w_enter_done;

  assign w_req_rgn    = mio_decode(mem_addr);
  assign w_req_take   = (r_state == MIO_S_IDLE) && mem_req;
  assign w_enter_done = (w_state_nxt == MIO_S_DONE);
  assign w_sw_ext     = 32'(sw_in);
  assign w_cnt_load   = (r_state == MIO_S_ACCESS) && r_we && (r_rgn == RGN_CNT) && !w_err_sel;

  mio_counter u_counter (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_load     (w_cnt_load),
    .i_load_val (r_wdata),
    .o_count    (w_count)
  );

  // next-state decode for the access sequencer
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MIO_S_IDLE: begin
        if (mem_req) w_state_nxt = MIO_S_ACCESS;
        else         w_state_nxt = MIO_S_IDLE;
      end
      MIO_S_ACCESS: begin
        if ((r_rgn == RGN_RAM) && RAM_HAS_WAIT) w_state_nxt = MIO_S_WAIT;
        else                                    w_state_nxt = MIO_S_DONE;
      end
      MIO_S_WAIT: begin
        if (r_wait_cnt == 3'd0) w_state_nxt = MIO_S_DONE;
        else                    w_state_nxt = MIO_S_WAIT;
      end
      MIO_S_DONE: w_state_nxt = MIO_S_IDLE;
      default:    w_state_nxt = MIO_S_IDLE;
    endcase
  end

  // read data source for the region being accessed
  always_comb begin
    w_rd_val = 32'd0;
    case (r_rgn)
      RGN_RAM:  w_rd_val = ram_rdata;
      RGN_GPIO: w_rd_val = w_sw_ext;
      RGN_CNT: begin
        if (w_err_sel) w_rd_val = w_err_word;
        else           w_rd_val = w_count;
      end
      default:  w_rd_val = 32'd0;
    endcase
  end

  // sequencer state, request latch, RAM strobes and completion outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= MIO_S_IDLE;
      r_rgn       <= RGN_RAM;
      r_we        <= 1'b0;
      r_wdata     <= 32'd0;
      r_wait_cnt  <= 3'd0;
      r_mem_rdata <= 32'd0;
      r_mio_ready <= 1'b0;
      r_ram_addr  <= 30'd0;
      r_ram_we    <= 1'b0;
      r_ram_wdata <= 32'd0;
      r_led       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_mio_ready <= w_enter_done;
      r_ram_we    <= 1'b0;
      if (w_req_take) begin
        r_rgn   <= w_req_rgn;
        r_we    <= mem_we;
        r_wdata <= mem_wdata;
        // RAM strobes are presented for the ACCESS cycle only
        if (w_req_rgn == RGN_RAM) begin
          r_ram_addr  <= mem_addr[31:2];
          r_ram_wdata <= mem_wdata;
          r_ram_we    <= mem_we;
        end
      end
      if (r_state == MIO_S_ACCESS) begin
        r_wait_cnt <= WAIT_INIT;
        if (r_we && (r_rgn == RGN_GPIO)) r_led <= r_wdata[LED_W-1:0];
      end else if ((r_state == MIO_S_WAIT) && (r_wait_cnt != 3'd0)) begin
        r_wait_cnt <= r_wait_cnt - 3'd1;
      end
      if (w_enter_done) r_mem_rdata <= r_we ? 32'd0 : w_rd_val;
    end
  end

`ifdef MIO_BUS_ERR_EN
  logic [31:0] r_addr;
  logic        r_fault;
  logic        r_bus_err;
  logic [31:0] r_err_addr;

  // fault detection and sticky capture of the last faulting address
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr     <= 32'd0;
      r_fault    <= 1'b0;
      r_bus_err  <= 1'b0;
      r_err_addr <= 32'd0;
    end else begin
      if (w_req_take) begin
        r_addr  <= mem_addr;
        r_fault <= (w_req_rgn == RGN_NONE) || (mem_addr[1:0] != 2'b00);
      end
      if ((r_state == MIO_S_ACCESS) && r_fault) r_err_addr <= r_addr;
      r_bus_err <= w_enter_done && r_fault;
    end
  end

  assign bus_err    = r_bus_err;
  assign w_err_sel  = (r_rgn == RGN_CNT) && (r_addr[27:2] == 26'd1);
  assign w_err_word = r_err_addr;
`else
  logic w_unused;

  assign w_unused   = ^mem_addr[1:0];
  assign w_err_sel  = 1'b0;
  assign w_err_word = 32'd0;
`endif

  assign mem_rdata = r_mem_rdata;
  assign MIO_ready = r_mio_ready;
  assign ram_addr  = r_ram_addr;
  assign ram_we    = r_ram_we;
  assign ram_wdata = r_ram_wdata;
  assign led_out   = r_led;

endmodule

// File: tb/tb_mio_bus_responder.sv
// Scoreboard bench for mio_bus_responder: one instance with RAM_LAT=1 and one
// with RAM_LAT=3, each with its own behavioural RAM of matching read latency.
module tb_mio_bus_responder;

  typedef struct {
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst3 = 1'b1;

  logic        req = 1'b0, we = 1'b0;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic [31:0] rdata, ram_wdata, ram_rdata;
  logic        rdy, ram_we;
  logic [29:0] ram_addr;
  logic [15:0] sw = 16'h0;
  logic [15:0] led;

  logic        req3 = 1'b0, we3 = 1'b0;
  logic [31:0] addr3 = 32'h0, wdata3 = 32'h0;
  logic [31:0] rdata3, ram_wdata3, ram_rdata3;
  logic        rdy3, ram_we3;
  logic [29:0] ram_addr3;
  logic [15:0] led3;

`ifdef MIO_BUS_ERR_EN
  logic berr, berr3;
  int   err_cnt = 0;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  mio_bus_responder #(.RAM_LAT(1), .LED_W(16), .SW_W(16)) dut (
    .clk(clk), .rst(rst), .mem_req(req), .mem_we(we), .mem_addr(addr),
    .mem_wdata(wdata), .mem_rdata(rdata), .MIO_ready(rdy), .ram_addr(ram_addr),
    .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .sw_in(sw), .led_out(led)
`ifdef MIO_BUS_ERR_EN
    , .bus_err(berr)
`endif
  );

  mio_bus_responder #(.RAM_LAT(3), .LED_W(16), .SW_W(16)) dut3 (
    .clk(clk), .rst(rst3), .mem_req(req3), .mem_we(we3), .mem_addr(addr3),
    .mem_wdata(wdata3), .mem_rdata(rdata3), .MIO_ready(rdy3), .ram_addr(ram_addr3),
    .ram_we(ram_we3), .ram_wdata(ram_wdata3), .ram_rdata(ram_rdata3),
    .sw_in(sw), .led_out(led3)
`ifdef MIO_BUS_ERR_EN
    , .bus_err(berr3)
`endif
  );

  // behavioural RAMs: latency 1 and latency 3
  logic [31:0] ram1 [0:63];
  logic [31:0] ram3 [0:63];
  logic [31:0] d3a, d3b;

  always @(posedge clk) begin
    if (ram_we) ram1[ram_addr[5:0]] <= ram_wdata;
    ram_rdata <= ram1[ram_addr[5:0]];
    if (ram_we3) ram3[ram_addr3[5:0]] <= ram_wdata3;
    d3a <= ram3[ram_addr3[5:0]];
    d3b <= d3a;
    ram_rdata3 <= d3b;
  end

  // event monitors sampled mid-cycle
  int          we_cnt1 = 0, we_cnt3 = 0, rdy_cnt1 = 0, rdy_cnt3 = 0;
  logic [29:0] we_addr1 = 30'h0;
  logic [31:0] we_data1 = 32'h0;

  always @(negedge clk) begin
    if (ram_we) begin
      we_cnt1  <= we_cnt1 + 1;
      we_addr1 <= ram_addr;
      we_data1 <= ram_wdata;
    end
    if (ram_we3) we_cnt3 <= we_cnt3 + 1;
    if (rdy) rdy_cnt1 <= rdy_cnt1 + 1;
    if (rdy3) rdy_cnt3 <= rdy_cnt3 + 1;
`ifdef MIO_BUS_ERR_EN
    if (rdy && berr) err_cnt <= err_cnt + 1;
`endif
  end

  task automatic issue(input bit sel, input logic [31:0] a, input bit w,
                       input logic [31:0] d, input logic [31:0] exp_rd, input int exp_lat);
    exp_t e;
    e.rdata = exp_rd;
    e.lat   = exp_lat;
    exp_q.push_back(e);
    if (sel) begin
      req3 = 1'b1; we3 = w; addr3 = a; wdata3 = d;
    end else begin
      req = 1'b1; we = w; addr = a; wdata = d;
    end
  endtask

  task automatic wait_done(input bit sel, output bit ok, output int lat, output logic [31:0] rd);
    ok = 1'b0; lat = 0; rd = 32'h0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(posedge clk); #1;
      if ((sel ? rdy3 : rdy) === 1'b1) begin
        ok  = 1'b1;
        lat = n + 1;
        rd  = sel ? rdata3 : rdata;
      end
    end
  endtask

  task automatic drop_req(input bit sel);
    if (sel) req3 = 1'b0;
    else     req  = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bit ok; int lat; logic [31:0] rd; exp_t e;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (rdy !== 1'b0 || rdata !== 32'h0) begin n_bad++; $display("FAIL reset_ready: ready=%b rdata=%h, want 0/00000000", rdy, rdata); end
    n_cmp++; if (ram_we !== 1'b0 || ram_addr !== 30'h0 || ram_wdata !== 32'h0) begin n_bad++; $display("FAIL reset_ram: we=%b addr=%h wdata=%h, want all 0", ram_we, ram_addr, ram_wdata); end
    n_cmp++; if (led !== 16'h0) begin n_bad++; $display("FAIL reset_led: got %h want 0000", led); end
    n_cmp++; if (rdy3 !== 1'b0 || rdata3 !== 32'h0 || ram_we3 !== 1'b0) begin n_bad++; $display("FAIL reset_dut3: ready=%b rdata=%h we=%b, want 0", rdy3, rdata3, ram_we3); end
    rst = 1'b0; rst3 = 1'b0;
    // counter is 0 at the last reset edge and 1 during the ACCESS cycle
    issue(1'b0, 32'hF000_0000, 1'b0, 32'h0, 32'h0000_0001, 2);
    wait_done(1'b0, ok, lat, rd); e = exp_q.pop_front();
    n_cmp++; if (!ok || rd !== e.rdata || lat != e.lat) begin n_bad++; $display("FAIL reset_counter: ready=%0b rdata=%h lat=%0d, want rdata=%h lat=%0d", ok, rd, lat, e.rdata, e.lat); end
    drop_req(1'b0);
  endtask

  task automatic test_ram();
    bit ok; int lat; logic [31:0] rd; exp_t e; int w0;
    w0 = we_cnt1;
    issue(1'b0, 32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 32'h0, 3);
    wait_done(1'b0, ok, lat, rd); e = exp_q.pop_front();
    n_cmp++; if (!ok || rd !== e.rdata || lat != e.lat) begin n_bad++; $display("FAIL ram_store: ready=%0b rdata=%h lat=%0d, want rdata=%h lat=%0d", ok, rd, lat, e.rdata, e.lat); end
    drop_req(1'b0);
    n_cmp++; if (we_cnt1 - w0 != 1) begin n_bad++; $display("FAIL ram_we_pulses: got %0d want 1", we_cnt1 - w0); end
    n_cmp++; if (we_addr1 !== 30'd4 || we_data1 !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL ram_we_addr: addr=%h data=%h, want 4/deadbeef", we_addr1, we_data1); end
    issue(1'b0, 32'h0000_0010, 1'b0, 32'h0, 32'hDEAD_BEEF, 3);
    wait_done(1'b0, ok, lat, rd); e = exp_q.pop_front();
    n_cmp++; if (!ok || rd !== e.rdata || lat != e.lat) begin n_bad++; $display("FAIL ram_load: ready=%0b rdata=%h lat=%0d, want rdata=%h lat=%0d", ok, rd, lat, e.rdata, e.lat); end
    drop_req(1'b0);
    // byte offset bits are ignored by the decode
    issue(1'b0, 32'h0000_0013, 1'b0, 32'h0, 32'hDEAD_BEEF, 3);
    wait_done(1'b0, ok, lat, rd); e = exp_q.pop_front();
    n_cmp++; if (!ok || rd !== e.rdata || lat != e.lat) begin n_bad++; $display("FAIL ram_load_unaligned: ready=%0b rdata=%h lat=%0d, want rdata=%h lat=%0d", ok, rd, lat, e.rdata, e.lat); end
    drop_req(1'b0);
    n_cmp++; if (we_cnt1 - w0 != 1) begin n_bad++; $display("FAIL ram_load_no_we: pulses %0d want 1", we_cnt1 - w0); end
  endtask

  task automatic test_gpio();
    bit ok; int lat; logic [31:0] rd; exp_t e;
    sw = 16'h1234;
    issue(1'b0, 32'hE000_0000, 1'b1, 32'h0000_A5A5, 32'h0, 2);
    wait_done(1'b0, ok, lat, rd); e = exp_q.pop_front();
    n_cmp++; if (!ok || rd !== e.rdata || lat != e.lat) begin n_bad++; $display("FAIL gpio_store: ready=%0b rdata=%h lat=%0d, want rdata=%h lat=%0d", ok, rd, lat, e.rdata, e.lat); end
    drop_req(1'b0);
    n_cmp++; if (led !== 16'hA5A5) begin n_bad++; $display("FAIL gpio_led: got %h want a5a5", led); end
    issue(1'b0, 32'hE000_0000, 1'b0, 32'h0, 32'h0000_1234, 2);
    wait_done(1'b0, ok, lat, rd); e = exp_q.pop_front();
    n_cmp++; if (!ok || rd !== e.rdata || lat != e.lat) begin n_bad++; $display("FAIL gpio_load: ready=%0b rdata=%h lat=%0d, want rdata=%h lat=%0d", ok, rd, lat, e.rdata, e.lat); end
    sw = 16'h0F0F;
    drop_req(1'b0);
    n_cmp++; if (rdata !== 32'h0000_1234) begin n_bad++; $display("FAIL gpio_rdata_hold: got %h want 00001234", rdata); end
    issue(1'b0, 32'hE000_0008, 1'b1, 32'hFFFF_5A5A, 32'h0, 2);
    wait_done(1'b0, ok, lat, rd); e = exp_q.pop_front();
    n_cmp++; if (!ok || rd !== e.rdata || lat != e.lat) begin n_bad++; $display("FAIL gpio_store2: ready=%0b rdata=%h lat=%0d, want rdata=%h lat=%0d", ok, rd, lat, e.rdata, e.lat); end
    drop_req(1'b0);
    n_cmp++; if (led !== 16'h5A5A) begin n_bad++; $display("FAIL gpio_led_trunc: got %h want 5a5a", led); end
  endtask

  task automatic test_counter();
    bit ok; int lat; logic [31:0] rd; exp_t e;
    issue(1'b0, 32'hF000_0000, 1'b1, 32'hFFFF_FFFE, 32'h0, 2);
    wait_done(1'b0, ok, lat, rd); e = exp_q.pop_front();
    n_cmp++; if (!ok || rd !== e.rdata || lat != e.lat) begin n_bad++; $display("FAIL cnt_write: ready=%0b rdata=%h lat=%0d, want rdata=%h lat=%0d", ok, rd, lat, e.rdata, e.lat); end
    drop_req(1'b0);
    @(posedge clk); #1;
    // read sampled 4 edges after the write request: FFFFFFFE + 3 wraps to 1
    issue(1'b0, 32'hF000_0000, 1'b0, 32'h0, 32'h0000_0001, 2);
    wait_done(1'b0, ok, lat, rd); e = exp_q.pop_front();
    n_cmp++; if (!ok || rd !== e.rdata || lat != e.lat) begin n_bad++; $display("FAIL cnt_wrap: ready=%0b rdata=%h lat=%0d, want rdata=%h lat=%0d", ok, rd, lat, e.rdata, e.lat); end
    drop_req(1'b0);
    issue(1'b0, 32'hF000_0000, 1'b0, 32'h0, 32'h0000_0004, 2);
    wait_done(1'b0, ok, lat, rd); e = exp_q.pop_front();
    n_cmp++; if (!ok || rd !== e.rdata || lat != e.lat) begin n_bad++; $display("FAIL cnt_run: ready=%0b rdata=%h lat=%0d, want rdata=%h lat=%0d", ok, rd, lat, e.rdata, e.lat); end
    drop_req(1'b0);
  endtask

  task automatic test_unmapped();
    bit ok; int lat; logic [31:0] rd; exp_t e; int w0;
`ifdef MIO_BUS_ERR_EN
    int e0;
    e0 = err_cnt;
`endif
    w0 = we_cnt1;
    issue(1'b0, 32'h3000_0000, 1'b0, 32'h0, 32'h0, 2);
    wait_done(1'b0, ok, lat, rd); e = exp_q.pop_front();
    n_cmp++; if (!ok || rd !== e.rdata || lat != e.lat) begin n_bad++; $display("FAIL unmapped_load: ready=%0b rdata=%h lat=%0d, want rdata=%h lat=%0d", ok, rd, lat, e.rdata, e.lat); end
    drop_req(1'b0);
    n_cmp++; if (rdy !== 1'b0) begin n_bad++; $display("FAIL unmapped_pulse: ready=%b one cycle later, want 0", rdy); end
`ifdef MIO_BUS_ERR_EN
    n_cmp++; if (err_cnt - e0 != 1) begin n_bad++; $display("FAIL unmapped_bus_err: pulses %0d want 1", err_cnt - e0); end
    issue(1'b0, 32'hF000_0004, 1'b0, 32'h0, 32'h3000_0000, 2);
    wait_done(1'b0, ok, lat, rd); e = exp_q.pop_front();
    n_cmp++; if (!ok || rd !== e.rdata || lat != e.lat) begin n_bad++; $display("FAIL err_addr_read: ready=%0b rdata=%h lat=%0d, want rdata=%h lat=%0d", ok, rd, lat, e.rdata, e.lat); end
    drop_req(1'b0);
`endif
    issue(1'b0, 32'h5000_0000, 1'b1, 32'h0000_1111, 32'h0, 2);
    wait_done(1'b0, ok, lat, rd); e = exp_q.pop_front();
    n_cmp++; if (!ok || rd !== e.rdata || lat != e.lat) begin n_bad++; $display("FAIL unmapped_store: ready=%0b rdata=%h lat=%0d, want rdata=%h lat=%0d", ok, rd, lat, e.rdata, e.lat); end
    drop_req(1'b0);
    n_cmp++; if (we_cnt1 != w0 || led !== 16'h5A5A) begin n_bad++; $display("FAIL unmapped_side_effect: we_pulses=%0d led=%h, want 0/5a5a", we_cnt1 - w0, led); end
  endtask

  task automatic test_back_to_back();
    bit ok; int lat; logic [31:0] rd; exp_t e; int c1, c2, r0;
    r0 = rdy_cnt1;
    sw = 16'h00AB;
    issue(1'b0, 32'hE000_0000, 1'b0, 32'h0, 32'h0000_00AB, 2);
    wait_done(1'b0, ok, lat, rd); e = exp_q.pop_front();
    c1 = cyc;
    n_cmp++; if (!ok || rd !== e.rdata || lat != e.lat) begin n_bad++; $display("FAIL b2b_first: ready=%0b rdata=%h lat=%0d, want rdata=%h lat=%0d", ok, rd, lat, e.rdata, e.lat); end
    @(posedge clk); #1;
    n_cmp++; if (rdy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_gap: ready=%b, want 0", rdy); end
    sw = 16'h00CD;
    issue(1'b0, 32'hE000_0004, 1'b0, 32'h0, 32'h0000_00CD, 2);
    wait_done(1'b0, ok, lat, rd); e = exp_q.pop_front();
    c2 = cyc;
    n_cmp++; if (!ok || rd !== e.rdata || lat != e.lat) begin n_bad++; $display("FAIL b2b_second: ready=%0b rdata=%h lat=%0d, want rdata=%h lat=%0d", ok, rd, lat, e.rdata, e.lat); end
    n_cmp++; if (c2 - c1 != 3) begin n_bad++; $display("FAIL b2b_spacing: got %0d cycles want 3", c2 - c1); end
    drop_req(1'b0);
    n_cmp++; if (rdy_cnt1 - r0 != 2) begin n_bad++; $display("FAIL b2b_pulses: got %0d want 2", rdy_cnt1 - r0); end
  endtask

  task automatic test_reset_wait();
    bit ok; int lat; logic [31:0] rd; exp_t e; int w0, r0;
    issue(1'b1, 32'h0000_0024, 1'b1, 32'hCAFE_F00D, 32'h0, 5);
    wait_done(1'b1, ok, lat, rd); e = exp_q.pop_front();
    n_cmp++; if (!ok || rd !== e.rdata || lat != e.lat) begin n_bad++; $display("FAIL lat3_store: ready=%0b rdata=%h lat=%0d, want rdata=%h lat=%0d", ok, rd, lat, e.rdata, e.lat); end
    drop_req(1'b1);
    w0 = we_cnt3; r0 = rdy_cnt3;
    req3 = 1'b1; we3 = 1'b1; addr3 = 32'h0000_0020; wdata3 = 32'h1234_5678;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst3 = 1'b1; req3 = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (rdy3 !== 1'b0 || rdata3 !== 32'h0 || ram_we3 !== 1'b0 || ram_addr3 !== 30'h0) begin n_bad++; $display("FAIL wait_reset_outputs: ready=%b rdata=%h we=%b addr=%h, want 0", rdy3, rdata3, ram_we3, ram_addr3); end
    rst3 = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    n_cmp++; if (we_cnt3 - w0 != 1 || rdy_cnt3 != r0) begin n_bad++; $display("FAIL wait_reset_abandon: we_pulses=%0d ready_pulses=%0d, want 1/0", we_cnt3 - w0, rdy_cnt3 - r0); end
    issue(1'b1, 32'h0000_0024, 1'b0, 32'h0, 32'hCAFE_F00D, 5);
    wait_done(1'b1, ok, lat, rd); e = exp_q.pop_front();
    n_cmp++; if (!ok || rd !== e.rdata || lat != e.lat) begin n_bad++; $display("FAIL wait_reset_next: ready=%0b rdata=%h lat=%0d, want rdata=%h lat=%0d", ok, rd, lat, e.rdata, e.lat); end
    drop_req(1'b1);
  endtask

  initial begin
    test_reset();
    test_ram();
    test_gpio();
    test_counter();
    test_unmapped();
    test_back_to_back();
    test_reset_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time limit, want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
